// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the dual-port asynchronous SRAM controller.
// Holds the controller FSM states, the requester port IDs and the
// legal range of the access-phase wait count.
package sram_ctrl_pkg;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned WAIT_CYCLES_MIN = 1;
  localparam int unsigned WAIT_CYCLES_MAX = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter between the instruction and data ports.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   req_if, req_d  pending requests
//   accept         the controller takes the current grant this cycle
//   grant_valid_c  at least one request pending (combinational)
//   grant_c        port that would be granted now (combinational)
// The last-grant register resets to PORT_IF, so the data port wins the
// first tie after reset.
module sram_rr_arbiter
  import sram_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req_if,
  input  logic  req_d,
  input  logic  accept,
  output logic  grant_valid_c,
  output port_e grant_c
);

  port_e last_q;

  // Remember who was served last; only accepted grants count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_IF;
    end else if (accept && grant_valid_c) begin
      last_q <= grant_c;
    end
  end

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_valid_c = req_if | req_d;
    grant_c       = PORT_D;
    if (req_if && req_d) begin
      grant_c = (last_q == PORT_D) ? PORT_IF : PORT_D;
    end else if (req_if) begin
      grant_c = PORT_IF;
    end
  end

endmodule

// File: rtl/sram_dual_port_ctrl.sv
// Dual-port (instruction read / data read-write) controller for an
// external asynchronous SRAM.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   if_req_i/if_addr_i             instruction read request
//   if_ack_o/if_rdata_o            instruction completion and read data
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request
//   d_ack_o/d_rdata_o              data completion and read data
//   sram_addr_o, sram_data_io      SRAM address and bidirectional data bus
//   sram_ce_n_o/oe_n_o/we_n_o      SRAM strobes (active low)
// Optional macro SRAM_BYTE_EN adds d_be_i and sram_be_n_o for
// byte-masked data writes; without it every write is full-word.
// All outputs are registered; the next strobe values are derived from
// the next FSM state so they line up with the state they describe.
module sram_dual_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
`ifdef SRAM_BYTE_EN
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic [DATA_W/8-1:0] sram_be_n_o,
`endif
  output logic                d_ack_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  inout  wire  [DATA_W-1:0]   sram_data_io,
  output logic                sram_ce_n_o,
  output logic                sram_oe_n_o,
  output logic                sram_we_n_o
);

  if (WAIT_CYCLES < WAIT_CYCLES_MIN || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait_cycles
    $error("sram_dual_port_ctrl: WAIT_CYCLES outside 1..15");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("sram_dual_port_ctrl: DATA_W must be a multiple of 8");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  port_e             port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drive_q, drive_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic              grant_valid_c;
  port_e             grant_c;
  logic              accept_c;
  logic              capture_c;

  sram_rr_arbiter u_arbiter (
    .clk           (clk_i),
    .rst_n         (rst_ni),
    .req_if        (if_req_i),
    .req_d         (d_req_i),
    .accept        (accept_c),
    .grant_valid_c (grant_valid_c),
    .grant_c       (grant_c)
  );

  // FSM state register; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, latched operation and next registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    accept_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          accept_c = 1'b1;
          state_d  = ACCESS;
          cnt_d    = CNT_W'(WAIT_CYCLES);
          port_d   = grant_c;
          if (grant_c == PORT_D) begin
            we_d    = d_we_i;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        // Counter runs WAIT_CYCLES..0, giving WAIT_CYCLES+1 access cycles.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // we_n rises on the final access cycle to give data hold time.
    ce_n_d   = !(state_d == ACCESS);
    oe_n_d   = !(state_d == ACCESS && !we_d);
    we_n_d   = !(state_d == ACCESS && we_d && cnt_d != '0);
    drive_d  = (state_d == ACCESS) && we_d;
    if_ack_d = (state_d == DONE) && (port_d == PORT_IF);
    d_ack_d  = (state_d == DONE) && (port_d == PORT_D);
  end

  // Read data is sampled on the edge that ends the last access cycle.
  assign capture_c = (state_q == ACCESS) && (cnt_q == '0) && !we_q;

  // Latched operation, strobes, acks and read-data registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      drive_q    <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      drive_q  <= drive_d;
      if_ack_q <= if_ack_d;
      d_ack_q  <= d_ack_d;
      if (capture_c && port_q == PORT_IF) begin
        if_rdata_q <= sram_data_io;
      end
      if (capture_c && port_q == PORT_D) begin
        d_rdata_q <= sram_data_io;
      end
    end
  end

`ifdef SRAM_BYTE_EN
  localparam int unsigned BE_W = DATA_W / 8;

  logic [BE_W-1:0] be_q, be_d;
  logic [BE_W-1:0] be_n_q, be_n_d;

  // Byte mask is latched with the operation; reads use all lanes.
  always_comb begin
    be_d = be_q;
    if (accept_c) begin
      be_d = (grant_c == PORT_D && d_we_i) ? d_be_i : '1;
    end
    be_n_d = '1;
    if (state_d == ACCESS) begin
      be_n_d = we_d ? ~be_d : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      be_q   <= '1;
      be_n_q <= '1;
    end else begin
      be_q   <= be_d;
      be_n_q <= be_n_d;
    end
  end

  assign sram_be_n_o = be_n_q;
`endif

  assign sram_data_io = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr_o  = addr_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign if_ack_o     = if_ack_q;
  assign d_ack_o      = d_ack_q;
  assign if_rdata_o   = if_rdata_q;
  assign d_rdata_o    = d_rdata_q;

endmodule

// File: tb/tb_sram_dual_port_ctrl.sv
// Bench for sram_dual_port_ctrl: an asynchronous SRAM model on the bus,
// and a reference built from the timing rules (access = WAIT+1 cycles,
// one DONE cycle with ack, one IDLE cycle between grants), round-robin
// order and a plain memory array. Honours SRAM_BYTE_EN when defined.
module tb_sram_dual_port_ctrl;

  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 32;
  localparam int unsigned WC  = 2;
  localparam int unsigned BEW = DW / 8;
  localparam int unsigned PER = WC + 3;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          if_req  = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req   = 1'b0;
  logic          d_we    = 1'b0;
  logic [AW-1:0] d_addr  = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;
  logic          ce_n;
  logic          oe_n;
  logic          we_n;
`ifdef SRAM_BYTE_EN
  logic [BEW-1:0] d_be = '1;
  logic [BEW-1:0] be_n;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_d_rdata  = '0;
  bit            last_d       = 1'b0;

  always #5 clk = ~clk;

  sram_dual_port_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_ack_o     (if_ack),
    .if_rdata_o   (if_rdata),
    .d_req_i      (d_req),
    .d_we_i       (d_we),
    .d_addr_i     (d_addr),
    .d_wdata_i    (d_wdata),
`ifdef SRAM_BYTE_EN
    .d_be_i       (d_be),
    .sram_be_n_o  (be_n),
`endif
    .d_ack_o      (d_ack),
    .d_rdata_o    (d_rdata),
    .sram_addr_o  (sram_addr),
    .sram_data_io (sram_data),
    .sram_ce_n_o  (ce_n),
    .sram_oe_n_o  (oe_n),
    .sram_we_n_o  (we_n)
  );

  // Asynchronous SRAM model: drives on ce&oe, stores while ce&we low.
  logic [DW-1:0]  sram_mem [256];
  logic [BEW-1:0] sram_be_act;
`ifdef SRAM_BYTE_EN
  assign sram_be_act = ~be_n;
`else
  assign sram_be_act = '1;
`endif
  assign sram_data = (!ce_n && !oe_n) ? sram_mem[sram_addr[7:0]] : {DW{1'bz}};

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      for (int b = 0; b < int'(BEW); b++) begin
        if (sram_be_act[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_data[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one or two simultaneous requests starting at a negedge with the
  // controller idle, and check every cycle up to the IDLE after the last ack.
  task automatic run(input bit want_if, input bit want_d, input bit dwe,
                     input logic [AW-1:0] ia, input logic [AW-1:0] da,
                     input logic [DW-1:0] dwd, input logic [BEW-1:0] dbe);
    bit            op_d [2];
    int            nops;
    int            slot;
    int            ph;
    bit            cur_d;
    bit            cur_we;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] mask;
    logic [DW-1:0] rd;
    logic [1:0]    exp_ack;
    logic [2:0]    exp_str;

    nops    = (want_if && want_d) ? 2 : 1;
    op_d[0] = (want_if && want_d) ? !last_d : want_d;
    op_d[1] = !op_d[0];
    mask    = '1;
`ifdef SRAM_BYTE_EN
    for (int b = 0; b < int'(BEW); b++) mask[8*b +: 8] = {8{dbe[b]}};
    d_be = dbe;
`endif
    if_req  = want_if;
    if_addr = ia;
    d_req   = want_d;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;

    for (int cyc = 1; cyc <= nops * int'(PER); cyc++) begin
      @(negedge clk);
      slot    = (cyc - 1) / int'(PER);
      ph      = (cyc - 1) % int'(PER);
      cur_d   = op_d[slot];
      cur_we  = cur_d && dwe;
      cur_a   = cur_d ? da : ia;
      exp_ack = 2'b00;
      exp_str = 3'b111;
      if (ph <= int'(WC)) begin
        exp_str = {1'b0, cur_we, cur_we ? (ph == int'(WC)) : 1'b1};
        check("access_addr", 64'(sram_addr), 64'(cur_a));
        if (cur_we) check("write_bus", 64'(sram_data), 64'(dwd));
`ifdef SRAM_BYTE_EN
        check("be_n", 64'(be_n), 64'(cur_we ? ~dbe : {BEW{1'b0}}));
`endif
      end else if (ph == int'(WC) + 1) begin
        exp_ack = cur_d ? 2'b01 : 2'b10;
        if (cur_we) begin
          ref_mem[da[7:0]] = (ref_mem[da[7:0]] & ~mask) | (dwd & mask);
        end else begin
          rd = ref_mem[cur_a[7:0]];
          if (cur_d) exp_d_rdata = rd;
          else       exp_if_rdata = rd;
        end
        last_d = cur_d;
        if (cur_d) d_req = 1'b0;
        else       if_req = 1'b0;
      end
      check("strobes_ce_oe_we", 64'({ce_n, oe_n, we_n}), 64'(exp_str));
      check("acks_if_d", 64'({if_ack, d_ack}), 64'(exp_ack));
      check("rdata_if_d", {if_rdata, d_rdata}, {exp_if_rdata, exp_d_rdata});
    end
  endtask

  initial begin
    int kind;

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_strobes", 64'({ce_n, oe_n, we_n}), 64'(3'b111));
    check("rst_acks", 64'({if_ack, d_ack}), 64'(2'b00));
    check("rst_rdata", {if_rdata, d_rdata}, 64'(0));
    check("rst_addr", 64'(sram_addr), 64'(0));
    rst_n = 1'b1;

    // Data write then instruction read of the same word
    run(1'b0, 1'b1, 1'b1, '0, 20'h00010, 32'hDEADBEEF, '1);
    run(1'b1, 1'b0, 1'b0, 20'h00010, '0, '0, '1);
    check("if_read_value", 64'(if_rdata), 64'(32'hDEADBEEF));

    // Two simultaneous request pairs: D, IF, D, IF
    run(1'b1, 1'b1, 1'b1, 20'h00010, 20'h00011, 32'h0BADF00D, '1);
    run(1'b1, 1'b1, 1'b0, 20'h00011, 20'h00010, '0, '1);
    check("pair_d_read", 64'(d_rdata), 64'(32'hDEADBEEF));
    check("pair_if_read", 64'(if_rdata), 64'(32'h0BADF00D));

`ifdef SRAM_BYTE_EN
    // Single-lane write merges into an existing word
    run(1'b0, 1'b1, 1'b1, '0, 20'h00040, 32'h11223344, '1);
    run(1'b0, 1'b1, 1'b1, '0, 20'h00040, 32'h0000AB00, 4'b0010);
    run(1'b1, 1'b0, 1'b0, 20'h00040, '0, '0, '1);
    check("be_merge_read", 64'(if_rdata), 64'(32'h1122AB44));
`endif

    // Fill a small window, then random traffic on it
    for (int i = 0; i < 16; i++) begin
      run(1'b0, 1'b1, 1'b1, '0, AW'(i), $urandom, '1);
    end
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      run(kind != 1, kind != 0, 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
          $urandom, BEW'($urandom));
    end

    // Leave IF as last grant, then abort a data write mid-access
    run(1'b1, 1'b0, 1'b0, 20'h00003, '0, '0, '1);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 20'h00030;
    d_wdata = $urandom;
    @(negedge clk);
    check("abort_acc1", 64'({ce_n, oe_n, we_n}), 64'(3'b010));
    @(negedge clk);
    check("abort_acc2", 64'({ce_n, oe_n, we_n}), 64'({2'b01, WC == 1}));
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    last_d       = 1'b0;
    check("abort_strobes", 64'({ce_n, oe_n, we_n}), 64'(3'b111));
    check("abort_acks", 64'({if_ack, d_ack}), 64'(2'b00));
    check("abort_addr", 64'(sram_addr), 64'(0));
    check("abort_rdata", {if_rdata, d_rdata}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_idle", 64'({ce_n, oe_n, we_n, if_ack, d_ack}), 64'(5'b11100));

    // Arbiter priority restored to the data port
    run(1'b1, 1'b1, 1'b0, 20'h00005, 20'h00006, '0, '1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
